// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM state encoding
// and the per-stage {stall,flush} control vector with canned decodes.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_MD_WAIT    = 2'd2,
    ST_REDIR_PEND = 2'd3
  } state_e;

  // One pipeline register's control pair; stall and flush must never both be set.
  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

  // Stage order follows the pipe, front to back.
  typedef struct packed {
    stage_ctrl_t if_id;
    stage_ctrl_t id_ex;
    stage_ctrl_t ex_mem;
    stage_ctrl_t mem_wb;
  } pipe_stage_ctrl_t;

  localparam pipe_stage_ctrl_t CTRL_NONE = '0;

  // Data-memory wait: freeze everything up to EX/MEM, bubble into WB.
  function automatic pipe_stage_ctrl_t ctrl_mem_freeze();
    pipe_stage_ctrl_t c;
    c              = CTRL_NONE;
    c.if_id.stall  = 1'b1;
    c.id_ex.stall  = 1'b1;
    c.ex_mem.stall = 1'b1;
    c.mem_wb.flush = 1'b1;
    return c;
  endfunction

  // Taken redirect: kill the three younger instructions.
  function automatic pipe_stage_ctrl_t ctrl_redirect_flush();
    pipe_stage_ctrl_t c;
    c              = CTRL_NONE;
    c.if_id.flush  = 1'b1;
    c.id_ex.flush  = 1'b1;
    c.ex_mem.flush = 1'b1;
    return c;
  endfunction

  // Mul/div busy: hold IF/ID and ID/EX, bubble into MEM.
  function automatic pipe_stage_ctrl_t ctrl_md_hold();
    pipe_stage_ctrl_t c;
    c              = CTRL_NONE;
    c.if_id.stall  = 1'b1;
    c.id_ex.stall  = 1'b1;
    c.ex_mem.flush = 1'b1;
    return c;
  endfunction

  // Fetch not ready: bubble into ID.
  function automatic pipe_stage_ctrl_t ctrl_fetch_bubble();
    pipe_stage_ctrl_t c;
    c             = CTRL_NONE;
    c.if_id.flush = 1'b1;
    return c;
  endfunction

  // Load-use: hold IF/ID, bubble into EX.
  function automatic pipe_stage_ctrl_t ctrl_load_use();
    pipe_stage_ctrl_t c;
    c             = CTRL_NONE;
    c.if_id.stall = 1'b1;
    c.id_ex.flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_seq_if.sv
// Hazard/event inputs and per-stage control outputs of the pipeline controller.
interface pipe_ctrl_seq_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic            load_use;
  logic            ex_mem_taken;
  logic [XLEN-1:0] ex_mem_target;
  logic            if_busy;
  logic            mem_busy;
  logic            md_start;
  logic            md_done;

  logic             pc_stall;
  logic             pc_redirect;
  logic [XLEN-1:0]  pc_target;
  logic             if_id_stall;
  logic             id_ex_stall;
  logic             ex_mem_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mem_wb_flush;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cycles;

  // Pipeline side: raises events, consumes controls.
  modport master (
    output load_use, ex_mem_taken, ex_mem_target, if_busy, mem_busy, md_start, md_done,
    input  pc_stall, pc_redirect, pc_target, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, md_busy, stall_cycles
  );

  // Controller side.
  modport slave (
    input  load_use, ex_mem_taken, ex_mem_target, if_busy, mem_busy, md_start, md_done,
    output pc_stall, pc_redirect, pc_target, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, md_busy, stall_cycles
  );
endinterface

// File: rtl/perf_stall_counter.sv
// Enable-gated free-running counter that wraps modulo 2^CNT_W.
module perf_stall_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Count enabled cycles; natural overflow provides the wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl_seq.sv
// Stall/flush sequencer for the 5-stage pipe. Merges load-use, taken redirect,
// fetch wait, data-memory wait and mul/div wait into one control set per cycle.
module pipe_ctrl_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input logic            clk,
  input logic            rst_n,
  pipe_ctrl_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pend_q, pend_d;
  pipe_stage_ctrl_t ctrl;
  logic             pc_stall_c;
  logic             pc_redirect_c;
  logic [XLEN-1:0]  pc_target_c;
  logic             run_eval;
  logic [CNT_W-1:0] cnt;
  logic             unused_mem_wb_stall;

  // State and latched redirect target.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= ST_RUN;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Next state and control decode; RUN priority list is shared by every
  // state that falls back to it.
  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d       = state_q;
    pend_d        = pend_q;
    ctrl          = CTRL_NONE;
    pc_stall_c    = 1'b0;
    pc_redirect_c = 1'b0;
    pc_target_c   = '0;
    run_eval      = 1'b0;

    unique case (state_q)
      // MEM_WAIT with mem_busy still high is exactly RUN rule 1, and with it
      // low the RUN rules apply in the same cycle, so both share the chain.
      ST_RUN, ST_MEM_WAIT: run_eval = 1'b1;
      ST_MD_WAIT: begin
        if (bus.mem_busy) begin
          run_eval = 1'b1;
        end else if (!bus.md_done) begin
          ctrl       = ctrl_md_hold();
          pc_stall_c = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_REDIR_PEND: begin
        ctrl = ctrl_fetch_bubble();
        if (bus.if_busy) begin
          pc_stall_c = 1'b1;
        end else begin
          pc_redirect_c = 1'b1;
          pc_target_c   = pend_q;
          state_d       = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (run_eval) begin
      state_d = ST_RUN;
      if (bus.mem_busy) begin
        ctrl       = ctrl_mem_freeze();
        pc_stall_c = 1'b1;
        state_d    = ST_MEM_WAIT;
      end else if (bus.ex_mem_taken && !bus.if_busy) begin
        ctrl          = ctrl_redirect_flush();
        pc_redirect_c = 1'b1;
        pc_target_c   = bus.ex_mem_target;
      end else if (bus.ex_mem_taken) begin
        ctrl       = ctrl_redirect_flush();
        pc_stall_c = 1'b1;
        pend_d     = bus.ex_mem_target;
        state_d    = ST_REDIR_PEND;
      end else if (bus.md_start && !bus.md_done) begin
        ctrl       = ctrl_md_hold();
        pc_stall_c = 1'b1;
        state_d    = ST_MD_WAIT;
      end else if (bus.if_busy) begin
        ctrl       = ctrl_fetch_bubble();
        pc_stall_c = 1'b1;
      end else if (bus.load_use) begin
        ctrl       = ctrl_load_use();
        pc_stall_c = 1'b1;
      end
    end
  end

  perf_stall_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pc_stall_c),
    .count (cnt)
  );

  // MEM/WB is never held; its stall slot exists only for a uniform vector.
  assign unused_mem_wb_stall = ctrl.mem_wb.stall;

  // All controls read as zero while reset is held.
  assign bus.pc_stall     = rst_n & pc_stall_c;
  assign bus.pc_redirect  = rst_n & pc_redirect_c;
  assign bus.pc_target    = rst_n ? pc_target_c : '0;
  assign bus.if_id_stall  = rst_n & ctrl.if_id.stall;
  assign bus.id_ex_stall  = rst_n & ctrl.id_ex.stall;
  assign bus.ex_mem_stall = rst_n & ctrl.ex_mem.stall;
  assign bus.if_id_flush  = rst_n & ctrl.if_id.flush;
  assign bus.id_ex_flush  = rst_n & ctrl.id_ex.flush;
  assign bus.ex_mem_flush = rst_n & ctrl.ex_mem.flush;
  assign bus.mem_wb_flush = rst_n & ctrl.mem_wb.flush;
  assign bus.md_busy      = rst_n & (state_q == ST_MD_WAIT);
  assign bus.stall_cycles = rst_n ? cnt : '0;

endmodule
